// File: rtl/simon_pkg.sv
// Shared types and constants for the sequence playback path of the Simon game.
package simon_pkg;

  localparam int SEQ_LEN = 100;

  typedef logic [1:0] color_t;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GAP
  } player_state_t;

  // Tone half-periods in clock cycles, one per colour; entry 0 is the largest.
  localparam int unsigned TONE_HALF [4] = '{95_556, 75_843, 63_776, 47_778};

  // Width of a down-counter that must hold values up to n-1; never zero.
  function automatic int count_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequence_player_if.sv
// Control and display bundle between the game controller and sequence_player.
interface sequence_player_if;
  import simon_pkg::*;

  logic       play;
  logic [6:0] level;
  color_t     game_sequence [SEQ_LEN];
  logic [3:0] leds;
  logic       busy;
  logic       done;
  logic [6:0] index;
  logic       tone;

  modport master (
    output play, level, game_sequence,
    input  leds, busy, done, index, tone
  );

  modport slave (
    input  play, level, game_sequence,
    output leds, busy, done, index, tone
  );

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter that parks at zero; zero flags expiry of the loaded span.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays entries 0..level-1 of the game sequence as timed LED flashes, then pulses done.
// Define SEQ_PLAYER_TONE_EN to add a per-colour square-wave tone during each flash.
module sequence_player
  import simon_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  sequence_player_if.slave  bus
);

  localparam int TW = count_width((ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [6:0]    SEQ_MAX  = 7'(SEQ_LEN);

  player_state_t state, state_next;
  logic [6:0]    lvl, index_q, index_inc, clamped;
  color_t        colour, colour_next;
  logic          done_q;
  logic          start, advance, finish;
  logic          timer_load, timer_zero;
  logic [TW-1:0] timer_value;

  assign clamped     = (bus.level > SEQ_MAX) ? SEQ_MAX : bus.level;
  assign index_inc   = index_q + 7'd1;
  assign colour_next = bus.game_sequence[start ? 7'd0 : index_inc];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lvl     <= '0;
      index_q <= '0;
      colour  <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= finish;
      if (start) begin
        lvl     <= clamped;
        index_q <= '0;
      end else if (advance) begin
        index_q <= index_inc;
      end
      if (start || advance) colour <= colour_next;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    timer_load  = 1'b0;
    timer_value = ON_LOAD;
    case (state)
      IDLE: begin
        if (bus.play) begin
          start = 1'b1;
          if (clamped == '0) begin
            finish = 1'b1;
          end else begin
            state_next = SHOW;
            timer_load = 1'b1;
          end
        end
      end
      SHOW: begin
        if (timer_zero) begin
          state_next  = GAP;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
      end
      GAP: begin
        if (timer_zero) begin
          if (index_q == lvl - 7'd1) begin
            state_next = IDLE;
            finish     = 1'b1;
          end else begin
            state_next = SHOW;
            advance    = 1'b1;
            timer_load = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.leds  = (state == SHOW) ? (4'b0001 << colour) : 4'b0000;
    bus.busy  = (state != IDLE);
    bus.done  = done_q;
    bus.index = index_q;
  end

  phase_timer #(.WIDTH(TW)) u_phase_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

`ifdef SEQ_PLAYER_TONE_EN
  localparam int TONE_W = count_width(TONE_HALF[0]);

  logic              show_entry, tone_load, tone_zero, tone_q;
  logic [TONE_W-1:0] tone_value;

  assign show_entry = (state_next == SHOW) && (state != SHOW);
  assign tone_load  = show_entry || ((state == SHOW) && (state_next == SHOW) && tone_zero);
  assign tone_value = TONE_W'(TONE_HALF[show_entry ? colour_next : colour] - 1);

  phase_timer #(.WIDTH(TONE_W)) u_tone_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tone_load),
    .value (tone_value),
    .zero  (tone_zero)
  );

  // Phase restarts low at every flash and is forced low outside SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q <= 1'b0;
    end else if ((state_next != SHOW) || show_entry) begin
      tone_q <= 1'b0;
    end else if (tone_zero) begin
      tone_q <= ~tone_q;
    end
  end

  assign bus.tone = tone_q;
`else
  assign bus.tone = 1'b0;
`endif

endmodule

// File: doc/sequence_player.md
# sequence_player

Plays the stored game sequence back to the player as timed LED flashes. It sits directly downstream of the sequence generator: it reads entries 0..level-1 of the frozen 100-entry colour array and drives one LED per entry for a fixed on-time, then a fixed dark gap. It pulses `done` when the last entry's gap has elapsed so the game controller can open the player-input phase.

## Interface
- `SEQ_LEN`, 100: number of entries in `game_sequence`.
- `ON_CYCLES`, 25_000_000: clock cycles each LED is lit (≥1).
- `OFF_CYCLES`, 12_500_000: clock cycles of dark gap after each flash (≥1).
- `clk`  input  1: single clock; all logic on posedge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `play`  input  1: start request, sampled only in IDLE.
- `level`  input  7: number of entries to show; latched on accepted `play`.
- `game_sequence`  input  [1:0] x SEQ_LEN: colour array from the generator.
- `leds`  output  4: one-hot of the current colour while lit, else 0.
- `busy`  output  1: high from the cycle after an accepted `play` until `done`.
- `done`  output  1: one-cycle pulse at end of playback.
- `index`  output  7: entry currently being shown.
- `tone`  output  1: audio square wave (see Configuration).

## Operation
- States: IDLE, SHOW, GAP.
- IDLE: `leds`=0, `busy`=0. On `play`=1: latch `lvl`=min(`level`, SEQ_LEN), `index`=0.
  - If `lvl`=0: stay IDLE, pulse `done` next cycle; no LEDs lit.
  - Else: go to SHOW, latch colour `game_sequence[0]`, load timer with ON_CYCLES-1.
- SHOW: `leds` = 1 << latched colour. Timer counts down; at 0 go to GAP and load OFF_CYCLES-1.
- GAP: `leds`=0. At timer 0: if `index`=`lvl`-1, go to IDLE and pulse `done`. Otherwise `index`+1, latch `game_sequence[index+1]`, reload ON_CYCLES-1, and go to SHOW.
- The colour is latched on SHOW entry. Changes to `game_sequence` during SHOW do not affect `leds`.
- `play` while `busy` is ignored; `level` changes after acceptance are ignored.
- Timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)).
- Colour mapping: 0→`leds`[0], 1→[1], 2→[2], 3→[3].

## Timing
- Reset values (asynchronous, immediate): state IDLE; `leds`=0, `busy`=0, `done`=0, `index`=0, `tone`=0, timer=0.
- Reset asserted mid-playback clears `leds` immediately. Playback does not resume after reset.
- `play` sampled high at edge E: from the cycle after E, state is SHOW, `busy`=1 and `leds` is valid.
- Each SHOW lasts exactly ON_CYCLES cycles; each GAP lasts exactly OFF_CYCLES cycles; no idle cycles between them.
- `done`=1 for exactly one cycle, `lvl`×(ON_CYCLES+OFF_CYCLES) cycles after the first SHOW cycle.
- `busy` falls in the same cycle that `done` rises.
- A new `play` is accepted in the `done` cycle itself.
- For `level`=0, `done` pulses the cycle after E and `busy` stays 0.

## Configuration
- `SEQ_PLAYER_TONE_EN` defined: during SHOW, `tone` toggles every `TONE_HALF[colour]` cycles using a separate counter that restarts at SHOW entry. `tone`=0 in IDLE and GAP.
- `SEQ_PLAYER_TONE_EN` undefined: `tone` is tied to 0 and no tone counter is synthesised.

## Structure
- Package `simon_pkg` holds:
  - `SEQ_LEN`.
  - `typedef logic [1:0] color_t`.
  - The player state enum `player_state_t` (IDLE/SHOW/GAP).
  - `TONE_HALF[4]` half-period constants.
- One sub-module, `phase_timer`: a loadable down-counter with a `zero` flag, used for the SHOW/GAP durations. The tone counter is a second instance of it.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=2.
- Reset, then idle for 10 cycles → `leds`=0, `busy`=0, `done` never asserted.
- `game_sequence`[0..2]={2,0,3}, `level`=3, one-cycle `play` → `leds` = 4'b0100 for 4 cycles, 0 for 2, 4'b0001 for 4, 0 for 2, 4'b1000 for 4, 0 for 2; `done` 18 cycles after the first SHOW cycle; `busy` high for exactly 18 cycles.
- `level`=0 with `play` → `done` pulses the next cycle, `leds` stays 0, `busy` stays 0.
- `level`=120 → playback clamps to 100 entries; `done` after 600 cycles; `index` ends at 99.
- `play` re-pulsed mid-playback, and `game_sequence[1]` changed during SHOW of entry 1 → neither the timing nor the current `leds` is affected.
- `rst_n` dropped during SHOW of entry 1 → `leds`=0 and `busy`=0 immediately; after release the block stays IDLE until a new `play`.
